// File: rtl/dispatch_stage_pkg.sv
// ---------------------------------------------------------------------------
// ooop_types : shared types for the out-of-order core front end.
//
// Contents:
//   N_PHYS_REGS / PREG_W : physical register file size and preg index width
//   ROB_TAG_W            : reorder-buffer tag width
//   DISP_DEPTH           : default dispatch queue depth
//   fu_type_t            : functional-unit class (FU_ALU / FU_LSU / FU_BRU)
//   rename_pkt_t         : packet produced by rename, consumed by dispatch
//   wake_pkt()           : applies one CDB broadcast to a packet's ready bits
// ---------------------------------------------------------------------------
package ooop_types;

    localparam int N_PHYS_REGS = 64;
    localparam int PREG_W      = $clog2(N_PHYS_REGS);
    localparam int ROB_TAG_W   = 5;
    localparam int DISP_DEPTH  = 2;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_BRU = 2'd2
    } fu_type_t;

    typedef struct packed {
        logic                 valid;
        fu_type_t             fu_type;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [PREG_W-1:0]    pdst;
        logic                 rs1_used;
        logic [PREG_W-1:0]    prs1;
        logic                 prs1_ready;
        logic                 rs2_used;
        logic [PREG_W-1:0]    prs2;
        logic                 prs2_ready;
    } rename_pkt_t;

    // A used source becomes ready when it names preg 0 (hard-wired ready) or
    // matches the broadcast tag. Unused sources are left untouched so that an
    // all-zero packet stays all-zero.
    function automatic rename_pkt_t wake_pkt(input rename_pkt_t       p,
                                             input logic              cdb_v,
                                             input logic [PREG_W-1:0] cdb_preg);
        rename_pkt_t r;
        r = p;
        if (p.rs1_used && ((p.prs1 == '0) || (cdb_v && (p.prs1 == cdb_preg))))
            r.prs1_ready = 1'b1;
        if (p.rs2_used && ((p.prs2 == '0) || (cdb_v && (p.prs2 == cdb_preg))))
            r.prs2_ready = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/dispatch_stage_buf.sv
// ---------------------------------------------------------------------------
// dispatch_buf : DEPTH-entry in-order circular FIFO of rename packets.
//
// Every valid entry snoops the CDB each cycle; a packet written this cycle
// also picks up a coincident broadcast. A flush empties the queue and takes
// priority over any push or pop in the same cycle.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_flush          empty the queue at the next edge
//   i_push, i_pkt    write i_pkt at the tail (caller guarantees not full)
//   i_pop            retire the head entry (caller guarantees not empty)
//   i_cdb_valid      CDB broadcast valid
//   i_cdb_preg       CDB destination preg
//   o_head_v         head entry holds a packet
//   o_head_pkt       registered head packet
//   o_count          number of occupied entries
// ---------------------------------------------------------------------------
module dispatch_buf
    import ooop_types::*;
#(
    parameter int DEPTH = DISP_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  rename_pkt_t                i_pkt,
    input  logic                       i_pop,
    input  logic                       i_cdb_valid,
    input  logic [PREG_W-1:0]          i_cdb_preg,
    output logic                       o_head_v,
    output rename_pkt_t                o_head_pkt,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rename_pkt_t        r_mem [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (r_vld[i])
                    r_mem[i] <= wake_pkt(r_mem[i], i_cdb_valid, i_cdb_preg);
            // The tail slot is never valid when a push is allowed, so this
            // write cannot collide with the wakeup update above.
            if (i_push) begin
                r_mem[r_tail] <= wake_pkt(i_pkt, i_cdb_valid, i_cdb_preg);
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (i_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head_v   = r_vld[r_head];
    assign o_head_pkt = r_mem[r_head];
    assign o_count    = r_count;

endmodule

// File: rtl/dispatch_stage.sv
// ---------------------------------------------------------------------------
// dispatch_stage : buffers renamed packets and issues the head packet to the
// ROB and to exactly one reservation station (ALU, LSU or BRU).
//
// Handshake: every downstream pair is valid/ready; a transfer happens in a
// cycle where valid and ready are both high. The head packet only leaves when
// the ROB and its selected RS both accept (fire); each side's valid is raised
// only when the other side is ready, so neither can take it alone. ready_out
// is a function of queue occupancy only, so rename never sees a combinational
// path from the downstream readies.
//
// Optional build macro DISPATCH_STATS_EN adds two saturating stall counters;
// without it both counter outputs are tied to zero.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush_i, recover_i         discard every buffered packet
//   valid_in, ready_out        rename -> dispatch handshake
//   pkt_in                     renamed packet
//   rob_valid_o, rob_ready_i   ROB allocate handshake
//   alu/lsu/bru_valid_o/_ready_i  RS issue handshakes
//   disp_pkt_o                 head packet with up-to-date ready bits
//   cdb_valid_i, cdb_preg_i    CDB broadcast snoop
//   stall_rob_cnt_o            cycles the head waited on the ROB
//   stall_rs_cnt_o             cycles the head waited on its RS
// ---------------------------------------------------------------------------
module dispatch_stage #(
    parameter int DEPTH       = ooop_types::DISP_DEPTH,
    parameter int N_PHYS_REGS = ooop_types::N_PHYS_REGS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic                            recover_i,
    input  logic                            valid_in,
    output logic                            ready_out,
    input  ooop_types::rename_pkt_t         pkt_in,
    output logic                            rob_valid_o,
    input  logic                            rob_ready_i,
    output logic                            alu_valid_o,
    input  logic                            alu_ready_i,
    output logic                            lsu_valid_o,
    input  logic                            lsu_ready_i,
    output logic                            bru_valid_o,
    input  logic                            bru_ready_i,
    output ooop_types::rename_pkt_t         disp_pkt_o,
    input  logic                            cdb_valid_i,
    input  logic [$clog2(N_PHYS_REGS)-1:0]  cdb_preg_i,
    output logic [31:0]                     stall_rob_cnt_o,
    output logic [31:0]                     stall_rs_cnt_o
);

    import ooop_types::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             w_kill;
    logic             w_push;
    logic             w_fire;
    logic             w_head_v;
    rename_pkt_t      w_head_pkt;
    rename_pkt_t      w_wake_pkt;
    logic [CNT_W-1:0] w_count;
    logic             w_sel_alu;
    logic             w_sel_lsu;
    logic             w_sel_bru;
    logic             w_tgt_ready;

    assign w_kill    = flush_i | recover_i;
    // While full, a same-cycle pop does not open a slot; that keeps
    // ready_out free of any downstream ready.
    assign ready_out = (w_count < CNT_W'(DEPTH));
    assign w_push    = valid_in & ready_out & ~w_kill;

    dispatch_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (w_kill),
        .i_push     (w_push),
        .i_pkt      (pkt_in),
        .i_pop      (w_fire),
        .i_cdb_valid(cdb_valid_i),
        .i_cdb_preg (cdb_preg_i),
        .o_head_v   (w_head_v),
        .o_head_pkt (w_head_pkt),
        .o_count    (w_count)
    );

    assign w_sel_alu   = (w_head_pkt.fu_type == FU_ALU);
    assign w_sel_lsu   = (w_head_pkt.fu_type == FU_LSU);
    assign w_sel_bru   = (w_head_pkt.fu_type == FU_BRU);
    assign w_tgt_ready = (w_sel_alu & alu_ready_i) |
                         (w_sel_lsu & lsu_ready_i) |
                         (w_sel_bru & bru_ready_i);

    assign w_fire      = w_head_v & rob_ready_i & w_tgt_ready & ~w_kill;

    assign rob_valid_o = w_head_v & w_tgt_ready & ~w_kill;
    assign alu_valid_o = w_head_v & rob_ready_i & w_sel_alu & ~w_kill;
    assign lsu_valid_o = w_head_v & rob_ready_i & w_sel_lsu & ~w_kill;
    assign bru_valid_o = w_head_v & rob_ready_i & w_sel_bru & ~w_kill;

    // A broadcast landing in the dispatch cycle itself would be lost by the
    // RS, so it is folded into the outgoing ready bits here.
    assign w_wake_pkt = wake_pkt(w_head_pkt, cdb_valid_i, cdb_preg_i);

    always_comb begin
        disp_pkt_o       = w_wake_pkt;
        disp_pkt_o.valid = w_fire;
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] r_stall_rob_cnt;
    logic [31:0] r_stall_rs_cnt;

    // Free-running observability counters: saturate, ignore flush/recover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_rob_cnt <= '0;
            r_stall_rs_cnt  <= '0;
        end else begin
            if (w_head_v && !rob_ready_i && (r_stall_rob_cnt != '1))
                r_stall_rob_cnt <= r_stall_rob_cnt + 32'd1;
            if (w_head_v && rob_ready_i && !w_tgt_ready && (r_stall_rs_cnt != '1))
                r_stall_rs_cnt <= r_stall_rs_cnt + 32'd1;
        end
    end

    assign stall_rob_cnt_o = r_stall_rob_cnt;
    assign stall_rs_cnt_o  = r_stall_rs_cnt;
`else
    assign stall_rob_cnt_o = 32'd0;
    assign stall_rs_cnt_o  = 32'd0;
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// ---------------------------------------------------------------------------
// tb_dispatch_stage : directed self-checking bench for dispatch_stage.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising (active) edge.
// ---------------------------------------------------------------------------
module tb_dispatch_stage;
  import ooop_types::*;

  localparam int PKT_W = $bits(rename_pkt_t);

`ifdef DISPATCH_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              flush_i = 1'b0;
  logic              recover_i = 1'b0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  rename_pkt_t       pkt_in = '0;
  logic              rob_valid_o;
  logic              rob_ready_i = 1'b1;
  logic              alu_valid_o;
  logic              alu_ready_i = 1'b1;
  logic              lsu_valid_o;
  logic              lsu_ready_i = 1'b1;
  logic              bru_valid_o;
  logic              bru_ready_i = 1'b1;
  rename_pkt_t       disp_pkt_o;
  logic              cdb_valid_i = 1'b0;
  logic [PREG_W-1:0] cdb_preg_i = '0;
  logic [31:0]       stall_rob_cnt_o;
  logic [31:0]       stall_rs_cnt_o;

  dispatch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .recover_i      (recover_i),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .pkt_in         (pkt_in),
    .rob_valid_o    (rob_valid_o),
    .rob_ready_i    (rob_ready_i),
    .alu_valid_o    (alu_valid_o),
    .alu_ready_i    (alu_ready_i),
    .lsu_valid_o    (lsu_valid_o),
    .lsu_ready_i    (lsu_ready_i),
    .bru_valid_o    (bru_valid_o),
    .bru_ready_i    (bru_ready_i),
    .disp_pkt_o     (disp_pkt_o),
    .cdb_valid_i    (cdb_valid_i),
    .cdb_preg_i     (cdb_preg_i),
    .stall_rob_cnt_o(stall_rob_cnt_o),
    .stall_rs_cnt_o (stall_rs_cnt_o)
  );

  // scoreboard
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  logic [PKT_W-1:0] exp_q[$];

  function automatic rename_pkt_t mk(input fu_type_t fu, input logic [4:0] tag,
                                     input logic r1u, input logic [5:0] p1, input logic r1,
                                     input logic r2u, input logic [5:0] p2, input logic r2);
    rename_pkt_t p;
    p.valid      = 1'b1;
    p.fu_type    = fu;
    p.rob_tag    = tag;
    p.pdst       = {1'b1, tag};
    p.rs1_used   = r1u;
    p.prs1       = p1;
    p.prs1_ready = r1;
    p.rs2_used   = r2u;
    p.prs2       = p2;
    p.prs2_ready = r2;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 64'({rob_valid_o, alu_valid_o, lsu_valid_o, bru_valid_o}), 64'd0);
  endtask

  // Any cycle in which ROB and an RS both see valid is a dispatch: the packet
  // must be the oldest outstanding expected one.
  task automatic sb_check();
    logic [PKT_W-1:0] e;
    if (rob_valid_o && (alu_valid_o || lsu_valid_o || bru_valid_o) &&
        rob_ready_i && ((alu_valid_o && alu_ready_i) || (lsu_valid_o && lsu_ready_i) ||
                        (bru_valid_o && bru_ready_i))) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_issue", 64'(disp_pkt_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_issue_pkt", 64'(disp_pkt_o), 64'(e));
      end
    end
  endtask

  task automatic settle();
    #1;
    sb_check();
  endtask

  initial begin
    rename_pkt_t p;

    // ---- reset state ----
    #1;
    chk("rst_ready_out", 64'(ready_out), 64'd1);
    chk_idle("rst_valids");
    chk("rst_disp_pkt", 64'(disp_pkt_o), 64'd0);
    chk("rst_stall_rob", 64'(stall_rob_cnt_o), 64'd0);
    chk("rst_stall_rs", 64'(stall_rs_cnt_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // ---- single ALU packet, all readies high ----
    @(negedge clk);
    valid_in = 1'b1;
    p = mk(FU_ALU, 5'd3, 1'b1, 6'd5, 1'b1, 1'b0, 6'd0, 1'b0);
    pkt_in = p; exp_q.push_back(p);
    settle();
    chk("t1_ready_out_push", 64'(ready_out), 64'd1);
    chk("t1_no_bypass", 64'(rob_valid_o), 64'd0);
    @(negedge clk); valid_in = 1'b0;
    settle();
    chk("t1_rob_valid", 64'(rob_valid_o), 64'd1);
    chk("t1_alu_valid", 64'(alu_valid_o), 64'd1);
    chk("t1_other_valids", 64'({lsu_valid_o, bru_valid_o}), 64'd0);
    chk("t1_ready_out_hold", 64'(ready_out), 64'd1);
    @(negedge clk);
    settle();
    chk_idle("t1_popped");
    chk("t1_ready_out_empty", 64'(ready_out), 64'd1);

    // ---- LSU then BRU with ROB stalled; fill, refuse, drain in order ----
    rob_ready_i = 1'b0;
    @(negedge clk);
    valid_in = 1'b1;
    p = mk(FU_LSU, 5'd4, 1'b1, 6'd8, 1'b1, 1'b1, 6'd9, 1'b1);
    pkt_in = p; exp_q.push_back(p);
    settle();
    chk("t2_ready_out_1st", 64'(ready_out), 64'd1);
    @(negedge clk);
    p = mk(FU_BRU, 5'd5, 1'b1, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    pkt_in = p;
    p.prs1_ready = 1'b1;  // preg 0 always ready
    exp_q.push_back(p);
    settle();
    chk("t2_ready_out_2nd", 64'(ready_out), 64'd1);
    chk("t2_rob_valid_wait", 64'(rob_valid_o), 64'd1);
    chk("t2_lsu_valid_wait", 64'(lsu_valid_o), 64'd0);
    chk("t2_disp_valid_wait", 64'(disp_pkt_o.valid), 64'd0);
    @(negedge clk);
    pkt_in = mk(FU_ALU, 5'd9, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);  // must be refused
    settle();
    chk("t2_full_ready_out", 64'(ready_out), 64'd0);
    @(negedge clk);
    valid_in = 1'b0; rob_ready_i = 1'b1;
    settle();
    chk("t2_lsu_first", 64'({lsu_valid_o, bru_valid_o}), 64'b10);
    chk("t2_stall_rob", 64'(stall_rob_cnt_o), STATS_ON ? 64'd2 : 64'd0);
    chk("t2_stall_rs", 64'(stall_rs_cnt_o), 64'd0);
    @(negedge clk);
    settle();
    chk("t2_bru_second", 64'({lsu_valid_o, bru_valid_o}), 64'b01);
    @(negedge clk);
    settle();
    chk_idle("t2_drained");
    chk("t2_ready_out_drained", 64'(ready_out), 64'd1);

    // ---- CDB wakeup: buffered and same-cycle, with RS stall ----
    alu_ready_i = 1'b0;
    @(negedge clk);
    valid_in = 1'b1;
    pkt_in = mk(FU_ALU, 5'd6, 1'b1, 6'd17, 1'b0, 1'b1, 6'd20, 1'b0);
    exp_q.push_back(mk(FU_ALU, 5'd6, 1'b1, 6'd17, 1'b1, 1'b1, 6'd20, 1'b1));
    settle();
    @(negedge clk);
    valid_in = 1'b0; cdb_valid_i = 1'b1; cdb_preg_i = 6'd17;
    settle();
    chk("t3_prs1_same_cycle", 64'(disp_pkt_o.prs1_ready), 64'd1);
    chk("t3_prs2_not_yet", 64'(disp_pkt_o.prs2_ready), 64'd0);
    chk("t3_rs_stall_rob_valid", 64'(rob_valid_o), 64'd0);
    chk("t3_rs_stall_alu_valid", 64'(alu_valid_o), 64'd1);
    @(negedge clk);
    cdb_valid_i = 1'b0;
    settle();
    chk("t3_prs1_stored", 64'(disp_pkt_o.prs1_ready), 64'd1);
    chk("t3_prs2_still_0", 64'(disp_pkt_o.prs2_ready), 64'd0);
    chk("t3_stall_rs_1", 64'(stall_rs_cnt_o), STATS_ON ? 64'd1 : 64'd0);
    @(negedge clk);
    alu_ready_i = 1'b1; cdb_valid_i = 1'b1; cdb_preg_i = 6'd20;
    settle();
    chk("t3_fire_rob_valid", 64'(rob_valid_o), 64'd1);
    chk("t3_fire_prs2_cdb", 64'(disp_pkt_o.prs2_ready), 64'd1);
    chk("t3_stall_rs_2", 64'(stall_rs_cnt_o), STATS_ON ? 64'd2 : 64'd0);
    chk("t3_stall_rob_hold", 64'(stall_rob_cnt_o), STATS_ON ? 64'd2 : 64'd0);
    @(negedge clk);
    cdb_valid_i = 1'b0;
    settle();
    chk_idle("t3_drained");

    // ---- recover with full buffer, push attempt and fire condition ----
    alu_ready_i = 1'b0;
    @(negedge clk);
    valid_in = 1'b1; pkt_in = mk(FU_ALU, 5'd10, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    settle();
    @(negedge clk);
    pkt_in = mk(FU_ALU, 5'd11, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    settle();
    @(negedge clk);
    pkt_in = mk(FU_ALU, 5'd12, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    alu_ready_i = 1'b1; recover_i = 1'b1;
    settle();
    chk_idle("t4_recover_kill");
    chk("t4_recover_disp_valid", 64'(disp_pkt_o.valid), 64'd0);
    chk("t4_recover_full", 64'(ready_out), 64'd0);
    @(negedge clk);
    recover_i = 1'b0; valid_in = 1'b0;
    settle();
    chk("t4_after_ready_out", 64'(ready_out), 64'd1);
    chk_idle("t4_after_empty");

    // ---- flush overrides a push accepted in the same cycle ----
    alu_ready_i = 1'b0;
    @(negedge clk);
    valid_in = 1'b1; pkt_in = mk(FU_ALU, 5'd13, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    settle();
    @(negedge clk);
    pkt_in = mk(FU_ALU, 5'd14, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    flush_i = 1'b1;
    settle();
    chk("t4_flush_ready_out", 64'(ready_out), 64'd1);
    chk_idle("t4_flush_kill");
    @(negedge clk);
    flush_i = 1'b0; valid_in = 1'b0; alu_ready_i = 1'b1;
    settle();
    chk_idle("t4_flush_dropped");
    chk("t4_flush_after_ready", 64'(ready_out), 64'd1);

    // ---- asynchronous reset between clock edges ----
    rob_ready_i = 1'b0;
    @(negedge clk);
    valid_in = 1'b1; pkt_in = mk(FU_ALU, 5'd15, 1'b1, 6'd3, 1'b1, 1'b0, 6'd0, 1'b0);
    settle();
    @(negedge clk);
    valid_in = 1'b0;
    settle();
    chk("t5_pre_rst_rob_valid", 64'(rob_valid_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("t5_async_valids");
    chk("t5_async_disp_pkt", 64'(disp_pkt_o), 64'd0);
    chk("t5_async_ready_out", 64'(ready_out), 64'd1);
    chk("t5_async_stall_rob", 64'(stall_rob_cnt_o), 64'd0);
    chk("t5_async_stall_rs", 64'(stall_rs_cnt_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rob_ready_i = 1'b1;
    settle();
    chk_idle("t5_post_rst_idle");

    chk("sb_all_issued", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
